// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, default
// byte width and a constant-evaluable clog2.
package uart_pkg;

    localparam int unsigned DATA_BITS_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid requester at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned GW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [GW-1:0]      rr_ptr_i,
    output logic [GW-1:0]      winner_o,
    output logic               any_valid_o
);

    logic [GW:0]   sum;
    logic [GW-1:0] idx;

    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // rr_ptr + k stays below 2*NUM_REQ, so a single subtract wraps it
            sum = {1'b0, rr_ptr_i} + (GW+1)'(k);
            if (sum >= (GW+1)'(NUM_REQ)) sum = sum - (GW+1)'(NUM_REQ);
            idx = sum[GW-1:0];
            if (!any_valid_o && req_valid_i[idx]) begin
                winner_o    = idx;
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte streams with round-robin
// arbitration and a packet lock bounded by MAX_BURST and TIMEOUT_CYCLES.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int unsigned DATA_BITS      = DATA_BITS_DEF,
    parameter  int unsigned NUM_REQ        = 4,
    parameter  int unsigned MAX_BURST      = 16,
    parameter  int unsigned TIMEOUT_CYCLES = 50000,
    localparam int unsigned GW             = clog2(NUM_REQ)
) (
    input  logic                         clk_50MHz,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         tx_busy,
    input  logic                         tx_done_tick,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic [GW-1:0]                grant_id,
    output logic                         grant_active,
    output logic                         forced_release
);

    localparam int unsigned BW = clog2(MAX_BURST + 1);
    localparam int unsigned TW = (clog2(TIMEOUT_CYCLES) < 1) ? 1 : clog2(TIMEOUT_CYCLES);

    state_e                 state_q, state_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]          grant_id_q, grant_id_d;
    logic                   grant_active_q, grant_active_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
    logic                   forced_q, forced_d;
    logic                   last_q, last_d;
    logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
    logic [TW-1:0]          timeout_cnt_q, timeout_cnt_d;

    logic [GW-1:0]          winner;
    logic                   any_valid;
    logic [DATA_BITS-1:0]   sel_data;
    logic                   release_c;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    // Byte offered by the current owner.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == GW'(i)) sel_data = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            tx_data_q      <= '0;
            tx_start_q     <= 1'b0;
            req_ready_q    <= '0;
            forced_q       <= 1'b0;
            last_q         <= 1'b0;
            burst_cnt_q    <= '0;
            timeout_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            req_ready_q    <= req_ready_d;
            forced_q       <= forced_d;
            last_q         <= last_d;
            burst_cnt_q    <= burst_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        tx_data_d      = tx_data_q;
        last_d         = last_q;
        burst_cnt_d    = burst_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        tx_start_d     = 1'b0;
        req_ready_d    = '0;
        forced_d       = 1'b0;
        release_c      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (any_valid && !tx_busy) begin
                    grant_id_d     = winner;
                    grant_active_d = 1'b1;
                    state_d        = S_SEND;
                end
            end
            S_SEND: begin
                if (req_valid[grant_id_q] && !tx_busy) begin
                    tx_data_d     = sel_data;
                    last_d        = req_last[grant_id_q];
                    tx_start_d    = 1'b1;
                    req_ready_d   = NUM_REQ'(1) << grant_id_q;
                    burst_cnt_d   = burst_cnt_q + BW'(1);
                    timeout_cnt_d = '0;
                    state_d       = S_WAIT_DONE;
                end else if (timeout_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    release_c = 1'b1;
                    forced_d  = 1'b1;
                end else if (timeout_cnt_q != '1) begin
                    timeout_cnt_d = timeout_cnt_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (tx_done_tick) begin
                    if (last_q) begin
                        release_c = 1'b1;
                    end else if (burst_cnt_q == BW'(MAX_BURST)) begin
                        release_c = 1'b1;
                        forced_d  = 1'b1;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Hand the pointer to the requester after the owner.
        if (release_c) begin
            rr_ptr_d       = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);
            grant_active_d = 1'b0;
            burst_cnt_d    = '0;
            timeout_cnt_d  = '0;
            state_d        = S_IDLE;
        end
    end

    assign req_ready      = req_ready_q;
    assign tx_start       = tx_start_q;
    assign tx_data        = tx_data_q;
    assign grant_id       = grant_id_q;
    assign grant_active   = grant_active_q;
    assign forced_release = forced_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: directed requester streams, a
// transmitter model with 10-cycle bytes, and a monitor checking every start.
module tb_uart_tx_scheduler;

    logic        clk_50MHz;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_busy;
    logic        tx_done_tick;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        grant_active;
    logic        forced_release;

    uart_tx_scheduler #(
        .DATA_BITS(8), .NUM_REQ(4), .MAX_BURST(16), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk_50MHz      (clk_50MHz),
        .reset          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .tx_busy        (tx_busy),
        .tx_done_tick   (tx_done_tick),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .grant_id       (grant_id),
        .grant_active   (grant_active),
        .forced_release (forced_release)
    );

    typedef struct {
        bit         forced;
        int         id;
        logic [7:0] data;
    } ev_t;

    ev_t        expq[$];
    logic [8:0] rq[4][$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         start_count = 0;
    int         last_start_cyc = 0;
    int         last_done_cyc = 0;
    int         last_forced_delta = -1;
    logic       busy_hold = 1'b0;

    initial clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;
    always @(posedge clk_50MHz) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push_start(input int id, input logic [7:0] d);
        ev_t e;
        e.forced = 1'b0; e.id = id; e.data = d;
        expq.push_back(e);
    endtask

    task automatic push_forced();
        ev_t e;
        e.forced = 1'b1; e.id = 0; e.data = 8'h00;
        expq.push_back(e);
    endtask

    task automatic load(input int id, input logic [7:0] d, input logic last);
        rq[id].push_back({last, d});
    endtask

    task automatic wait_start(input string name, input int sc0);
        int n = 0;
        while (start_count == sc0 && n < 200) begin
            @(negedge clk_50MHz); #1;
            n++;
        end
        chk(name, 32'(start_count != sc0), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((expq.size() != 0 || grant_active || tx_busy) && n < 3000) begin
            @(negedge clk_50MHz); #1;
            n++;
        end
        chk({name, "_drain"}, 32'(expq.size()), 32'd0);
        chk({name, "_idle"}, 32'(grant_active), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({name, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({name, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({name, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({name, "_grant_active"}, 32'(grant_active), 32'd0);
        chk({name, "_forced"}, 32'(forced_release), 32'd0);
    endtask

    // Requesters: hold the head byte until req_ready, then advance.
    initial begin
        req_valid = '0; req_data = '0; req_last = '0;
        forever begin
            @(negedge clk_50MHz); #2;
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i]        = rq[i].size() > 0;
                req_data[i*8 +: 8]  = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
                req_last[i]         = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
            end
        end
    end

    // Transmitter: busy for 10 cycles after tx_start, then one done tick.
    initial begin
        int  cnt;
        logic busy_m;
        cnt = 0; busy_m = 1'b0; tx_busy = 1'b0; tx_done_tick = 1'b0;
        forever begin
            @(negedge clk_50MHz); #3;
            tx_done_tick = 1'b0;
            if (!rst_n) begin
                busy_m = 1'b0; cnt = 0;
            end else if (tx_start) begin
                busy_m = 1'b1; cnt = 10;
            end else if (busy_m) begin
                cnt--;
                if (cnt == 0) begin
                    busy_m = 1'b0;
                    tx_done_tick = 1'b1;
                    last_done_cyc = cyc + 1;
                end
            end
            tx_busy = busy_m | busy_hold;
        end
    end

    // Monitor: every start or forced release must match the head of the queue.
    always @(negedge clk_50MHz) begin
        ev_t e;
        if (rst_n) begin
            if (forced_release) begin
                last_forced_delta = cyc - last_done_cyc;
                total++;
                if (expq.size() == 0 || !expq[0].forced) begin
                    bad++;
                    $display("FAIL forced_release unexpected got=1 exp=0 owner=%0d", grant_id);
                end else begin
                    void'(expq.pop_front());
                end
            end
            if (tx_start) begin
                start_count++;
                last_start_cyc = cyc;
                total++;
                if (expq.size() == 0 || expq[0].forced) begin
                    bad++;
                    $display("FAIL tx_start unexpected got id=%0d data=%02h", grant_id, tx_data);
                end else begin
                    e = expq.pop_front();
                    if (int'(grant_id) != e.id || tx_data !== e.data || !grant_active ||
                        req_ready !== (4'b0001 << e.id)) begin
                        bad++;
                        $display("FAIL tx_start got id=%0d data=%02h rdy=%b act=%0d exp id=%0d data=%02h",
                                 grant_id, tx_data, req_ready, grant_active, e.id, e.data);
                    end
                end
            end else if (req_ready != 4'b0000) begin
                total++;
                bad++;
                $display("FAIL req_ready_without_start got=%b exp=0000", req_ready);
            end
        end
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog expired got=running exp=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int c0;
        int sc0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk_50MHz); #1;
        rst_n = 1'b1;

        // Single owner, 3-byte packet; 2-cycle first-byte latency.
        @(negedge clk_50MHz); #1;
        push_start(1, 8'h41); push_start(1, 8'h42); push_start(1, 8'h43);
        load(1, 8'h41, 1'b0); load(1, 8'h42, 1'b0); load(1, 8'h43, 1'b1);
        c0 = cyc; sc0 = start_count;
        wait_start("t1_start", sc0);
        chk("t1_latency", 32'(last_start_cyc - c0), 32'd2);
        wait_idle("t1");
        chk("t1_grant_id_kept", 32'(grant_id), 32'd1);

        // Pointer now at 2: requester 2 beats requester 0.
        @(negedge clk_50MHz); #1;
        push_start(2, 8'h52); push_start(0, 8'h50);
        load(0, 8'h50, 1'b1); load(2, 8'h52, 1'b1);
        wait_idle("rr2");

        // From reset, 0 and 2 alternate whole 2-byte packets.
        @(negedge clk_50MHz); #1;
        rst_n = 1'b0;
        push_start(0, 8'hA0); push_start(0, 8'hA1);
        push_start(2, 8'hB0); push_start(2, 8'hB1);
        push_start(0, 8'hA2); push_start(0, 8'hA3);
        load(0, 8'hA0, 1'b0); load(0, 8'hA1, 1'b1); load(0, 8'hA2, 1'b0); load(0, 8'hA3, 1'b1);
        load(2, 8'hB0, 1'b0); load(2, 8'hB1, 1'b1);
        repeat (2) @(negedge clk_50MHz);
        #1;
        rst_n = 1'b1;
        wait_idle("t2");

        // Burst limit: 16 from 3, forced release, 0's packet, 3 resumes.
        @(negedge clk_50MHz); #1;
        for (int k = 0; k < 16; k++) push_start(3, 8'(8'h60 + k));
        push_forced();
        push_start(0, 8'h90);
        for (int k = 16; k < 20; k++) push_start(3, 8'(8'h60 + k));
        for (int k = 0; k < 20; k++) load(3, 8'(8'h60 + k), k == 19);
        load(0, 8'h90, 1'b1);
        wait_idle("t3");
        chk("t3_forced_on_done", 32'(last_forced_delta), 32'd0);

        // Owner stalls mid-packet: forced release 20 cycles after the done tick.
        @(negedge clk_50MHz); #1;
        push_start(1, 8'hA1); push_forced(); push_start(2, 8'hB5);
        load(1, 8'hA1, 1'b0); load(2, 8'hB5, 1'b1);
        wait_idle("t4");
        chk("t4_timeout_delay", 32'(last_forced_delta), 32'd20);

        // Transmitter busy at the request: no start until it frees.
        @(negedge clk_50MHz); #1;
        busy_hold = 1'b1;
        push_start(0, 8'h33);
        load(0, 8'h33, 1'b1);
        sc0 = start_count;
        repeat (15) @(negedge clk_50MHz);
        #1;
        chk("t5_no_start_busy", 32'(start_count), 32'(sc0));
        chk("t5_no_grant_busy", 32'(grant_active), 32'd0);
        @(negedge clk_50MHz); #1;
        busy_hold = 1'b0;
        c0 = cyc;
        wait_start("t5_start", sc0);
        chk("t5_latency", 32'(last_start_cyc - c0), 32'd2);
        wait_idle("t5");

        // Reset mid-byte, then requester 0 wins over 2 from pointer 0.
        @(negedge clk_50MHz); #1;
        push_start(2, 8'hC0);
        load(2, 8'hC0, 1'b0); load(2, 8'hC1, 1'b1);
        sc0 = start_count;
        wait_start("t6_start", sc0);
        repeat (3) @(negedge clk_50MHz);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("t6_async_reset");
        push_start(0, 8'hD0); push_start(2, 8'hC1);
        load(0, 8'hD0, 1'b1);
        repeat (2) @(negedge clk_50MHz);
        #1;
        rst_n = 1'b1;
        wait_idle("t6");

        repeat (5) @(negedge clk_50MHz);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter among NUM_REQ byte-stream requesters, e.g. an RX-FIFO echo path, a status reporter and a command responder.
- Uses round-robin arbitration with a packet lock: the winner keeps the transmitter until it marks its last byte, hits MAX_BURST, or stalls past TIMEOUT_CYCLES.
- Sits between the requesters and uart_transmitter, and drives that transmitter's tx_start and data_in.

Parameters:
- DATA_BITS, 8, byte width.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before a forced release.
- TIMEOUT_CYCLES, 50000, idle clk cycles in SEND before a forced release (1 ms at 50 MHz).

Ports:
- clk_50MHz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte on req_data slice i.
- req_data  in  NUM_REQ*DATA_BITS  packed bytes; slice i = [i*DATA_BITS +: DATA_BITS].
- req_last  in  NUM_REQ  the byte is the last of its packet.
- req_ready  out  NUM_REQ  one-cycle accept pulse; the byte is consumed.
- tx_busy  in  1  from uart_transmitter.
- tx_done_tick  in  1  from uart_transmitter; one-cycle pulse at the end of the stop bit.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  DATA_BITS  byte to the transmitter; held stable from tx_start until tx_done_tick.
- grant_id  out  clog2(NUM_REQ)  current or last owner.
- grant_active  out  1  a requester owns the transmitter.
- forced_release  out  1  one-cycle pulse on a MAX_BURST or timeout release.

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE; rr_ptr 0.
  - All outputs 0.
  - Burst and timeout counters 0.
- All outputs are registered.
- IDLE state:
  - If any req_valid and tx_busy is 0: winner = first valid index at or after rr_ptr, searching cyclically.
  - Latch the winner into grant_id, set grant_active, go to SEND.
- SEND state:
  - If req_valid[grant_id] and tx_busy is 0, in the same cycle:
    - Latch req_data slice into tx_data and req_last into last_q.
    - Pulse req_ready[grant_id] and tx_start.
    - Increment burst_cnt, clear timeout_cnt, go to WAIT_DONE.
  - Otherwise increment timeout_cnt. When it reaches TIMEOUT_CYCLES-1: release.
- WAIT_DONE state:
  - On tx_done_tick, release if any of these hold:
    - last_q is 1.
    - burst_cnt equals MAX_BURST.
    - req_valid has no bit set other than grant_id's and the owner's packet is ongoing. This rule does NOT apply: the lock holds until last_q, burst limit or timeout.
  - On tx_done_tick with no release: return to SEND.
- Release:
  - rr_ptr = grant_id+1, wrapping modulo NUM_REQ.
  - Clear grant_active, burst_cnt and timeout_cnt.
  - Go to IDLE.
  - Pulse forced_release only when the release was caused by MAX_BURST without last_q, or by timeout.
- Latency: a valid request in IDLE with the transmitter idle reaches tx_start 2 cycles after req_valid is sampled (IDLE→SEND, then the SEND issue cycle).
- Back-to-back bytes from the same owner: tx_start comes 1 cycle after tx_done_tick.
- Exactly one req_ready bit pulses per tx_start, and never while tx_busy is 1.
- Requesters must hold req_data and req_last stable while req_valid is 1 and not yet accepted.
- tx_done_tick outside WAIT_DONE is ignored.
- tx_busy is sampled only in IDLE and SEND.
- A req_valid bit dropping in SEND without acceptance is legal; the timeout counts.
- Reset mid-byte: the scheduler returns to IDLE immediately. The transmitter is reset from the same net, so the byte is abandoned, with no req_ready re-pulse.
- Simultaneous valids: strict round robin from rr_ptr. Any requester with continuous demand is granted within NUM_REQ-1 packets.
- MAX_BURST=1: one byte per grant (byte-level round robin).
- Counters:
  - burst_cnt width clog2(MAX_BURST+1).
  - timeout_cnt width clog2(TIMEOUT_CYCLES), saturating.

Decomposition:
- Shared package uart_pkg:
  - State encoding: S_IDLE, S_SEND, S_WAIT_DONE.
  - DATA_BITS default.
  - A clog2 function.
- One natural sub-module: rr_arbiter.
  - Combinational priority search from rr_ptr over req_valid.
  - Outputs winner index and any_valid.
  - Unit-testable alone.
- The top scheduler holds the FSM, counters and output registers.

Test Plan:
- Single requester 1 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43) while tx_done_tick is modelled 10 cycles after each tx_start → three tx_start pulses with tx_data 0x41/0x42/0x43, req_ready[1] three times, grant_active falls after the third tx_done_tick, rr_ptr=2.
- Requesters 0 and 2 both valid from reset, each sending 2-byte packets → order 0,0,2,2, then 0 again if it is still valid; grant never switches mid-packet.
- Requester 3 streams 20 bytes with MAX_BURST=16 and requester 0 also valid → 16 bytes from 3, forced_release pulse, 0's packet, then 3 resumes with byte 17.
- Requester 1 is granted, sends one non-last byte, then drops req_valid → after TIMEOUT_CYCLES (bench value 20) forced_release pulses, state IDLE, the next valid requester is served.
- tx_busy held 1 at the first request → no tx_start until tx_busy falls, then tx_start 2 cycles later.
- reset asserted 3 cycles after tx_start → all outputs 0 asynchronously; after release rr_ptr is 0 and requester 0 wins over 2.
